// File: rtl/button_conditioner_pkg.sv
// Shared defaults, state encoding and small helpers for the push-button conditioner.
package button_conditioner_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    localparam logic [1:0] ST_IDLE_ENC     = 2'b00;
    localparam logic [1:0] ST_CHECK_HI_ENC = 2'b01;
    localparam logic [1:0] ST_HELD_ENC     = 2'b10;
    localparam logic [1:0] ST_CHECK_LO_ENC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_CHECK_HI = ST_CHECK_HI_ENC,
        ST_HELD     = ST_HELD_ENC,
        ST_CHECK_LO = ST_CHECK_LO_ENC
    } state_t;

    // The committed level is high only once a press has been accepted and not yet released.
    function automatic logic is_high_state(input state_t s);
        return (s == ST_HELD) || (s == ST_CHECK_LO);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchronizer bringing the asynchronous button level into the clk domain.
module btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw level through the flop chain; the oldest stage is the only safe output.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a push-button, producing a clean level, press/release pulses
// and a modulo-256 press counter.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       level,
    output logic       P1,
    output logic       rel_pulse,
    output logic [7:0] press_count
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             press_evt_s;
    logic             rel_evt_s;
    logic             level_r;
    logic             p1_r;
    logic             rel_r;
    logic [7:0]       press_count_r;

    btn_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_s)
    );

    // Debounce FSM: a level is committed only after DEBOUNCE_CYCLES consecutive agreeing samples.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        press_evt_s = 1'b0;
        rel_evt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    state_nxt_s = ST_CHECK_HI;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_CHECK_HI: begin
                if (!sync_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                    press_evt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_CHECK_HI;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!sync_s) begin
                    state_nxt_s = ST_CHECK_LO;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_CHECK_LO: begin
                if (sync_s) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    rel_evt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_CHECK_LO;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; pulses line up with the edge that commits the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            level_r       <= 1'b0;
            p1_r          <= 1'b0;
            rel_r         <= 1'b0;
            press_count_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            level_r <= is_high_state(state_nxt_s);
            p1_r    <= press_evt_s;
            rel_r   <= rel_evt_s;
            if (press_evt_s) begin
                press_count_r <= press_count_r + 8'd1;
            end else begin
                press_count_r <= press_count_r;
            end
        end
    end

    assign level       = level_r;
    assign P1          = p1_r;
    assign rel_pulse   = rel_r;
    assign press_count = press_count_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus randomized bench for button_conditioner against a run-length debounce model.
module tb_button_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       level;
    logic       P1;
    logic       rel_pulse;
    logic [7:0] press_count;

    button_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .level       (level),
        .P1          (P1),
        .rel_pulse   (rel_pulse),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int p1_seen  = 0;
    int rel_seen = 0;

    // Reference model: the sampled level is the input delayed by SYNC edges, and the committed
    // level flips once the last DEB samples all disagree with it.
    logic       m_level;
    logic       m_p1;
    logic       m_rel;
    logic [7:0] m_cnt;
    logic       btn_q[$];
    logic       samp_q[$];

    function automatic void model_edge(input logic b, input logic r);
        logic s;
        bit   all_diff;
        if (r) begin
            btn_q.delete();
            for (int i = 0; i < SYNC; i++) btn_q.push_back(1'b0);
            samp_q.delete();
            m_level = 1'b0;
            m_p1    = 1'b0;
            m_rel   = 1'b0;
            m_cnt   = 8'd0;
        end else begin
            s = btn_q.pop_front();
            btn_q.push_back(b);
            samp_q.push_back(s);
            if (samp_q.size() > DEB) void'(samp_q.pop_front());
            m_p1  = 1'b0;
            m_rel = 1'b0;
            if (samp_q.size() == DEB) begin
                all_diff = 1'b1;
                foreach (samp_q[i]) if (samp_q[i] == m_level) all_diff = 1'b0;
                if (all_diff) begin
                    m_level = ~m_level;
                    m_p1    = m_level;
                    m_rel   = ~m_level;
                    if (m_p1) m_cnt = m_cnt + 8'd1;
                    samp_q.delete();
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        chk("level", {31'd0, level}, {31'd0, m_level});
        chk("P1", {31'd0, P1}, {31'd0, m_p1});
        chk("rel_pulse", {31'd0, rel_pulse}, {31'd0, m_rel});
        chk("press_count", {24'd0, press_count}, {24'd0, m_cnt});
        chk("p1_rel_exclusive", {31'd0, (P1 & rel_pulse)}, 32'd0);
        if (P1 === 1'b1) p1_seen++;
        if (rel_pulse === 1'b1) rel_seen++;
    endtask

    initial begin
        int first_p1;
        int first_rel;
        int len;
        logic b;

        btn_in = 1'b0;
        rst    = 1'b1;

        // Reset state
        step(1'b1, 1'b1);
        chk("reset_level", {31'd0, level}, 32'd0);
        chk("reset_count", {24'd0, press_count}, 32'd0);

        // Clean press: P1 after the 6th edge with btn high
        p1_seen  = 0;
        first_p1 = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            if (P1 === 1'b1 && first_p1 == 0) first_p1 = i;
        end
        chk("press_latency", first_p1, SYNC + DEB);
        chk("press_pulses", p1_seen, 32'd1);
        chk("press_count_1", {24'd0, press_count}, 32'd1);
        chk("press_level", {31'd0, level}, 32'd1);

        // Two-cycle low glitch while held: no release
        rel_seen = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("glitch_rel", rel_seen, 32'd0);
        chk("glitch_level", {31'd0, level}, 32'd1);

        // Release: rel_pulse after the 6th low edge
        rel_seen  = 0;
        first_rel = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0);
            if (rel_pulse === 1'b1 && first_rel == 0) first_rel = i;
        end
        chk("release_latency", first_rel, SYNC + DEB);
        chk("release_pulses", rel_seen, 32'd1);
        chk("release_level", {31'd0, level}, 32'd0);

        // Bounce 1,0,1,0 then low
        step(1'b0, 1'b1);
        p1_seen  = 0;
        rel_seen = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        chk("bounce_p1", p1_seen, 32'd0);
        chk("bounce_rel", rel_seen, 32'd0);
        chk("bounce_count", {24'd0, press_count}, 32'd0);

        // Wrap: 256 clean presses return the counter to zero
        p1_seen = 0;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        end
        chk("wrap_pulses", p1_seen, 32'd256);
        chk("wrap_count", {24'd0, press_count}, 32'd0);

        // Reset in the middle of the debounce window with the button still held
        step(1'b0, 1'b1);
        p1_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("midreset_no_p1", p1_seen, 32'd0);
        first_p1 = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            if (P1 === 1'b1 && first_p1 == 0) first_p1 = i;
        end
        chk("midreset_latency", first_p1, SYNC + DEB);
        chk("midreset_pulses", p1_seen, 32'd1);

        // Randomized bursts with occasional resets
        for (int k = 0; k < 400; k++) begin
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                step(b, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth (>=2).
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, 4, consecutive stable samples needed to commit a level (>=2).
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: btn_in  input  1  raw asynchronous push-button level, may bounce.
REQ-006 SHALL have port: level  output  1  debounced button level.
REQ-007 SHALL have port: P1  output  1  one-cycle press pulse; drives the Mealy machine P1 input directly.
REQ-008 SHALL have port: rel_pulse  output  1  one-cycle release pulse.
REQ-009 SHALL have port: press_count  output  8  number of committed presses, modulo 256.
REQ-010 SHALL have one clock (clk) and reset rst, synchronous and active-high; no other clock or asynchronous reset.

Function
REQ-011 SHALL pass btn_in through a SYNC_STAGES-deep flop chain; only the last stage (sync) feeds logic.
REQ-012 SHALL implement FSM states IDLE (stable low), CHECK_HI, HELD (stable high), CHECK_LO, with a counter cnt wide enough for DEBOUNCE_CYCLES-1.
REQ-013 IDLE: sync=1 -> CHECK_HI, cnt=1; else stay.
REQ-014 CHECK_HI: sync=0 -> IDLE, cnt=0 (bounce, no output); sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; else cnt+1.
REQ-015 HELD: sync=0 -> CHECK_LO, cnt=1; else stay.
REQ-016 CHECK_LO: sync=1 -> HELD, cnt=0; sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-017 P1 SHALL be registered, high for exactly the one cycle following the CHECK_HI->HELD edge.
REQ-018 rel_pulse SHALL be registered, high for exactly the one cycle following the CHECK_LO->IDLE edge.
REQ-019 level SHALL be 1 in HELD and CHECK_LO, 0 in IDLE and CHECK_HI, registered.
REQ-020 Latency: with btn_in held high from before edge 1, P1 SHALL be high after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 at defaults) and low after the next edge.
REQ-021 press_count SHALL increment on the same edge that sets P1; 255 wraps to 0.
REQ-022 Any bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no P1, no rel_pulse, no level change.
REQ-023 P1 and rel_pulse SHALL never be high in the same cycle; a held button SHALL yield exactly one P1.

Reset
REQ-024 rst high at an edge SHALL clear synchronizer flops, cnt, press_count, level, P1, rel_pulse to 0 and FSM to IDLE; rst overrides all other inputs.
REQ-025 Reset mid-CHECK_HI or mid-HELD SHALL emit no pulse; a button still held after reset SHALL require full synchronizer plus debounce latency before P1.

Structure
REQ-026 State encoding localparams and default SYNC_STAGES/DEBOUNCE_CYCLES SHALL live in a shared package.
REQ-027 Synchronizer SHALL be a sub-module btn_sync (parameter STAGES, ports clk, rst, d, q); FSM, counters, outputs stay in button_conditioner.

Verification
REQ-028 Clean press: rst 1 for 1 cycle, btn_in=1 for 20 cycles -> one P1 pulse after edge 6, press_count=1, level=1 from that edge on.
REQ-029 Bounce: btn_in toggles 1,0,1,0 each cycle then stays 0 -> P1, rel_pulse, level stay 0; press_count=0.
REQ-030 Release: after REQ-028, btn_in=0 -> rel_pulse one cycle after edge 6 of low, level=0; a 2-cycle low glitch while held produces no rel_pulse.
REQ-031 Wrap: 256 clean press/release cycles -> press_count returns to 0, 256 P1 pulses counted.
REQ-032 Reset mid-press: assert rst while in CHECK_HI, keep btn_in=1 -> no P1 before reset, exactly one P1 6 cycles after rst drops.
REQ-033 Integration: P1 wired to Mealy_Machine P1; press, release, press sequence -> Mealy z matches its standalone response to single-cycle P1 pulses.
